// File: rtl/stall_pkg.sv
// Shared types and constants for the stall sequencer.
// Build option: STALL_CNT_EN enables the stall performance counter.
package stall_pkg;

  typedef enum logic [1:0] {
    ST_RUN = 2'd0,
    ST_HZ  = 2'd1,
    ST_MC  = 2'd2
  } stall_state_e;

  localparam int SRC_HZ  = 0;
  localparam int SRC_MC  = 1;
  localparam int SRC_MEM = 2;
  localparam int SRC_DBG = 3;

  localparam int DEF_HZ_CYCLES  = 1;
  localparam int DEF_MC_TIMEOUT = 32;
  localparam int DEF_TMR_W      = 6;
  localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/stall_timer.sv
// Shared stall timer: load/decrement for hazards, clear/increment for
// multicycle ops, with zero and match flags.
module stall_timer #(
  parameter int TMR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [TMR_W-1:0] ld_val,
  input  logic             dec,
  input  logic             inc,
  input  logic             clr,
  input  logic [TMR_W-1:0] match_val,
  output logic             zero,
  output logic             match
);

  logic [TMR_W-1:0] val;

  always_ff @(posedge clk) begin
    if (!rst) begin
      val <= '0;
    end else if (clr) begin
      val <= '0;
    end else if (ld) begin
      val <= ld_val;
    end else if (dec) begin
      val <= val - 1'b1;
    end else if (inc) begin
      val <= val + 1'b1;
    end
  end

  assign zero  = (val == '0);
  assign match = (val == match_val);

endmodule

// File: rtl/stall_ctrl.sv
// Stall sequencer driving the pipeline clock-gater enable.
// Build option: STALL_CNT_EN adds the saturating stall_cnt output.
module stall_ctrl
  import stall_pkg::*;
#(
  parameter int HZ_CYCLES  = DEF_HZ_CYCLES,
  parameter int MC_TIMEOUT = DEF_MC_TIMEOUT,
  parameter int TMR_W      = DEF_TMR_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_req,
  input  logic             mc_req,
  input  logic             mc_done,
  input  logic             mem_wait,
  input  logic             ext_hold,
  output logic             stallb_en,
  output logic [3:0]       stall_src,
  output logic             timeout_err
`ifdef STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  localparam logic [TMR_W-1:0] HZ_LD =
    TMR_W'(HZ_CYCLES - 1);
  localparam logic [TMR_W-1:0] MC_LAST =
    TMR_W'(MC_TIMEOUT - 1);

  stall_state_e state, state_nx;
  logic tmr_ld, tmr_dec, tmr_inc, tmr_clr;
  logic tmr_zero, tmr_match;
  logic to_nx;
  logic [3:0] src_nx;

  stall_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ld       (tmr_ld),
    .ld_val   (HZ_LD),
    .dec      (tmr_dec),
    .inc      (tmr_inc),
    .clr      (tmr_clr),
    .match_val(MC_LAST),
    .zero     (tmr_zero),
    .match    (tmr_match)
  );

  // mc_done wins over a coincident timeout
  always_comb begin
    state_nx = state;
    tmr_ld   = 1'b0;
    tmr_dec  = 1'b0;
    tmr_inc  = 1'b0;
    tmr_clr  = 1'b0;
    to_nx    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (mc_req) begin
          state_nx = ST_MC;
          tmr_clr  = 1'b1;
        end else if (hz_req) begin
          state_nx = ST_HZ;
          tmr_ld   = 1'b1;
        end
      end
      ST_HZ: begin
        if (tmr_zero) state_nx = ST_RUN;
        else          tmr_dec  = 1'b1;
      end
      ST_MC: begin
        if (mc_done) begin
          state_nx = ST_RUN;
        end else if (tmr_match) begin
          state_nx = ST_RUN;
          to_nx    = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_nx = ST_RUN;
    endcase
  end

  always_comb begin
    src_nx = '0;
    if (ext_hold)              src_nx[SRC_DBG] = 1'b1;
    else if (mem_wait)         src_nx[SRC_MEM] = 1'b1;
    else if (state_nx == ST_MC) src_nx[SRC_MC] = 1'b1;
    else if (state_nx == ST_HZ) src_nx[SRC_HZ] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_RUN;
      stallb_en   <= 1'b1;
      stall_src   <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      stallb_en   <= !((state_nx != ST_RUN) ||
                       mem_wait || ext_hold);
      stall_src   <= src_nx;
      timeout_err <= to_nx;
    end
  end

`ifdef STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!stallb_en && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed plan plus random traffic
// against an edge-numbered reference model.
module tb_stall_ctrl;

  localparam int HZ    = 2;
  localparam int MC_TO = 32;
  localparam int TW    = 6;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic hz_req = 1'b0;
  logic mc_req = 1'b0;
  logic mc_done = 1'b0;
  logic mem_wait = 1'b0;
  logic ext_hold = 1'b0;
  logic stallb_en;
  logic [3:0] stall_src;
  logic timeout_err;
`ifdef STALL_CNT_EN
  logic [CW-1:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  stall_ctrl #(
    .HZ_CYCLES (HZ),
    .MC_TIMEOUT(MC_TO),
    .TMR_W     (TW),
    .CNT_W     (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hz_req     (hz_req),
    .mc_req     (mc_req),
    .mc_done    (mc_done),
    .mem_wait   (mem_wait),
    .ext_hold   (ext_hold),
    .stallb_en  (stallb_en),
    .stall_src  (stall_src),
    .timeout_err(timeout_err)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // model: which stall is pending (0 none, 1 hazard, 2 multicycle)
  // and the edge number at which it ends on its own
  int n = 0;
  int kind = 0;
  int rel = 0;
  logic e_stb = 1'b1;
  logic e_err = 1'b0;
  logic [3:0] e_src = 4'd0;
  int e_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic model_edge();
    n++;
    if (!rst) begin
      kind = 0;
      e_stb = 1'b1;
      e_src = 4'd0;
      e_err = 1'b0;
      e_cnt = 0;
      return;
    end
    if (!e_stb && e_cnt < CMAX) e_cnt++;
    e_err = 1'b0;
    if (kind == 0) begin
      if (mc_req) begin
        kind = 2;
        rel = n + MC_TO;
      end else if (hz_req) begin
        kind = 1;
        rel = n + HZ;
      end
    end else if (kind == 1) begin
      if (n == rel) kind = 0;
    end else begin
      if (mc_done) begin
        kind = 0;
      end else if (n == rel) begin
        kind = 0;
        e_err = 1'b1;
      end
    end
    e_stb = !(kind != 0 || mem_wait || ext_hold);
    if (ext_hold)       e_src = 4'b1000;
    else if (mem_wait)  e_src = 4'b0100;
    else if (kind == 2) e_src = 4'b0010;
    else if (kind == 1) e_src = 4'b0001;
    else                e_src = 4'b0000;
  endtask

  task automatic tick(input logic r, input logic h, input logic m,
                      input logic d, input logic mw, input logic eh);
    rst = r;
    hz_req = h;
    mc_req = m;
    mc_done = d;
    mem_wait = mw;
    ext_hold = eh;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("stallb_en", int'(stallb_en), int'(e_stb));
    chk("stall_src", int'(stall_src), int'(e_src));
    chk("timeout_err", int'(timeout_err), int'(e_err));
`ifdef STALL_CNT_EN
    chk("stall_cnt", int'(stall_cnt), e_cnt);
`endif
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic mw, eh;
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 1, 0, 1, 1);
    chk("rst_stb", int'(stallb_en), 1);
    chk("rst_src", int'(stall_src), 0);
    chk("rst_err", int'(timeout_err), 0);

    // load-use hazard: two stalled cycles
    idle(9);
    tick(1, 1, 0, 0, 0, 0);
    chk("hz_stb0", int'(stallb_en), 0);
    chk("hz_src", int'(stall_src), 1);
    tick(1, 1, 0, 0, 0, 0);
    chk("hz_stb1", int'(stallb_en), 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("hz_rel", int'(stallb_en), 1);
    tick(1, 1, 0, 0, 0, 0);
    chk("hz_b2b", int'(stallb_en), 0);
    idle(3);

    // multicycle completed by mc_done
    tick(1, 0, 1, 0, 0, 0);
    chk("mc_src", int'(stall_src), 2);
    idle(6);
    chk("mc_hold", int'(stallb_en), 0);
    tick(1, 0, 0, 1, 0, 0);
    chk("mc_rel", int'(stallb_en), 1);
    chk("mc_noerr", int'(timeout_err), 0);
    idle(2);

    // multicycle timeout
    tick(1, 0, 1, 0, 0, 0);
    idle(MC_TO - 1);
    chk("to_hold", int'(stallb_en), 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("to_rel", int'(stallb_en), 1);
    chk("to_err", int'(timeout_err), 1);
    tick(1, 0, 0, 0, 0, 0);
    chk("to_err_pulse", int'(timeout_err), 0);

    // coincident hz+mc under mem_wait
    tick(1, 1, 1, 0, 1, 0);
    chk("mix_mem", int'(stall_src), 4);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("mix_mc", int'(stall_src), 2);
    chk("mix_stb", int'(stallb_en), 0);
    tick(1, 0, 0, 1, 0, 0);
    chk("mix_rel", int'(stallb_en), 1);

    // reset mid-multicycle
    tick(1, 0, 1, 0, 0, 0);
    idle(3);
    tick(0, 0, 0, 0, 0, 0);
    chk("mrst_stb", int'(stallb_en), 1);
    chk("mrst_src", int'(stall_src), 0);
    tick(1, 0, 0, 1, 0, 0);
    chk("mrst_done", int'(stallb_en), 1);
    chk("mrst_err", int'(timeout_err), 0);

`ifdef STALL_CNT_EN
    tick(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) tick(1, 0, 0, 0, 0, 1);
    chk("cnt_sat", int'(stall_cnt), 15);
`endif

    // random traffic
    mw = 1'b0;
    eh = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(9) == 0) mw = ~mw;
      if ($urandom_range(19) == 0) eh = ~eh;
      tick(logic'($urandom_range(499) != 0),
           logic'($urandom_range(7) == 0),
           logic'($urandom_range(11) == 0),
           logic'($urandom_range(39) == 0),
           mw, eh);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stall_ctrl.md
# stall_ctrl

Stall sequencer for the processor pipeline. Arbitrates stall requests from hazard detection, the multicycle unit, memory and debug hold, and drives the single `stallb_en` line consumed by the pipeline clock gater. The gater freezes fetch, decode and execute in that order on successive cycles. Runs on the rising edge of the ungated core clock.

## Interface
Parameters:
- `HZ_CYCLES`, default 1: stall length, in cycles, per load-use hazard pulse (1..2^TMR_W-1).
- `MC_TIMEOUT`, default 32: maximum cycles to wait for `mc_done` before forced release.
- `TMR_W`, default 6: internal timer width; must satisfy `MC_TIMEOUT < 2^TMR_W`.
- `CNT_W`, default 32: stall performance counter width.

Ports:
- `clk`, in, 1: ungated core clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-low.
- `hz_req`, in, 1: load-use hazard, single-cycle pulse.
- `mc_req`, in, 1: multicycle op issued, single-cycle pulse.
- `mc_done`, in, 1: multicycle op result ready, pulse.
- `mem_wait`, in, 1: memory not ready; level, stall while high.
- `ext_hold`, in, 1: debug hold; level, stall while high.
- `stallb_en`, out, 1: registered; 1 = run, 0 = stall.
- `stall_src`, out, 4: registered one-hot cause {ext_hold, mem_wait, mc, hz}; 0 when running.
- `timeout_err`, out, 1: one-cycle pulse on multicycle timeout.
- `stall_cnt`, out, CNT_W: total stalled cycles. Present only with the macro; see Configuration.

## Operation
- FSM states: RUN, HZ, MC.
  - RUN -> MC on `mc_req`. Timer cleared.
  - RUN -> HZ on `hz_req` with no `mc_req`. Timer loaded with HZ_CYCLES-1.
  - HZ: timer decrements each cycle. Exit to RUN on the cycle the timer is 0.
  - MC: timer increments each cycle. Exit to RUN on `mc_done`, or when timer reaches MC_TIMEOUT-1. A timeout exit also pulses `timeout_err`.
- Level sources (`mem_wait`, `ext_hold`) are ORed over the FSM. They do not change state, and the HZ/MC timers keep running under them.
- `stallb_en` next = !(next_state != RUN || mem_wait || ext_hold).
- `stall_src` priority: ext_hold > mem_wait > mc > hz. Only the highest active cause is reported.
- Ignored inputs, with no effect:
  - `hz_req` or `mc_req` while in HZ or MC, because the pipeline is frozen and the requester re-asserts after release.
  - `mc_done` outside MC.
- `mc_done` arriving in the same cycle as timeout is treated as normal completion: no `timeout_err`.
- Reset (`rst` low at a rising edge) takes effect at any point, including mid-stall:
  - state = RUN, timer = 0
  - `stallb_en` = 1, `stall_src` = 0, `timeout_err` = 0, `stall_cnt` = 0

## Timing
- A request sampled at edge k drives `stallb_en` = 0 from just after edge k.
- The gater samples `stallb_en` on the following falling edge: fetch freezes within half a cycle, decode one cycle later, execute two cycles later.
- `hz_req` at edge k gives `stallb_en` = 0 for exactly HZ_CYCLES cycles. It returns to 1 after edge k+HZ_CYCLES.
- `mc_req` at k and `mc_done` at edge d give `stallb_en` = 0 from k to d, and 1 after edge d.
- Without `mc_done`, release happens after edge k+MC_TIMEOUT. `timeout_err` is high for that same single cycle.
- Level sources give one cycle of latency on both assertion and deassertion.
- Back-to-back: a new `hz_req` sampled in the first RUN cycle after release starts a fresh stall. There is no enforced run gap.

## Configuration
- `STALL_CNT_EN` defined:
  - `stall_cnt` port present.
  - Counts +1 each cycle `stallb_en` is 0.
  - Saturates at all-ones; no wrap.
- Undefined: port and counter are absent, and all other behaviour is identical.

## Structure
- Package `stall_pkg` holds:
  - the state enum (RUN/HZ/MC)
  - `stall_src` bit indices (SRC_HZ=0, SRC_MC=1, SRC_MEM=2, SRC_DBG=3)
  - default parameter constants
- One sub-module, `stall_timer`: TMR_W load/decrement/increment/clear counter with zero and match flags. It serves both HZ and MC.

## Test plan
- Reset, then `hz_req` pulse at cycle 10 with HZ_CYCLES=2 -> `stallb_en` 0 for cycles 11-12, 1 at 13; `stall_src` = 4'b0001 during the stall.
- `mc_req` at cycle 5, `mc_done` at cycle 12 -> `stallb_en` 0 for cycles 6-12, 1 at 13; no `timeout_err`.
- `mc_req` with no `mc_done`, MC_TIMEOUT=32 -> release after 32 cycles; `timeout_err` is a single pulse on the release cycle.
- `hz_req` and `mc_req` in the same cycle, with `mem_wait` high for cycles 3-20 -> state MC; `stall_src` shows mem_wait (4'b0100) while high, then mc; `stallb_en` stays 0 until both are clear.
- `rst` low mid-MC at cycle 8 -> `stallb_en` = 1 and `stall_src` = 0 next cycle; a later `mc_done` is ignored.
- With `STALL_CNT_EN`, CNT_W=4, `ext_hold` high for 20 cycles -> `stall_cnt` saturates at 15.
